tmds_encoder_multi: RTL and testbench

Parametrised, pipelined multi-channel TMDS encoder, successor to the single-channel tmds_encoder. Encodes NUM_CH lanes in parallel, each with its own running-disparity counter. Adds mode select (control / video / TERC4 / guard band) so one block serves the DVI and HDMI transmit paths. Sits between the video timing/pixel pipeline and the 10:1 serialisers.

---
 rtl/tmds_encoder_multi.sv | 182 ++++++++++++++++++
 tb/tb_tmds_encoder_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_multi.sv
// Multi-lane pipelined TMDS encoder: control, video, TERC4 and guard-band symbols.
// Define TMDS_TERC4_EN to enable TERC4 data-island (mode 10) and guard-band (mode 11)
// encoding; without it both modes fall back to control-symbol encoding.
module tmds_encoder_multi #(
  parameter  int unsigned NUM_CH  = 3,
  parameter  int unsigned OUT_REG = 0,
  localparam int unsigned DW      = 8,
  localparam int unsigned CW      = 2,
  localparam int unsigned AW      = 4,
  localparam int unsigned SW      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [NUM_CH*DW-1:0] data,
  input  logic [NUM_CH*CW-1:0] ctrl,
  input  logic [NUM_CH*AW-1:0] aux,
  output logic [NUM_CH*SW-1:0] tmds
);

  typedef enum logic [1:0] {
    MODE_CTRL  = 2'b00,
    MODE_VIDEO = 2'b01,
    MODE_TERC4 = 2'b10,
    MODE_GUARD = 2'b11
  } mode_e;

  function automatic logic [3:0] popcount8(input logic [DW-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < int'(DW); k++) c = c + 4'(v[k]);
    return c;
  endfunction

  function automatic logic [SW-1:0] ctrl_sym(input logic [CW-1:0] c);
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [SW-1:0] terc4_sym(input logic [AW-1:0] a);
    case (a)
      4'h0:    return 10'b1010011100;
      4'h1:    return 10'b1001100011;
      4'h2:    return 10'b1011100100;
      4'h3:    return 10'b1011100010;
      4'h4:    return 10'b0101110001;
      4'h5:    return 10'b0100011110;
      4'h6:    return 10'b0110001110;
      4'h7:    return 10'b0100111100;
      4'h8:    return 10'b1011001100;
      4'h9:    return 10'b0100111001;
      4'hA:    return 10'b0110011100;
      4'hB:    return 10'b1011000110;
      4'hC:    return 10'b1010001110;
      4'hD:    return 10'b1001110001;
      4'hE:    return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction
`else
  logic unused_aux;
  assign unused_aux = ^aux;
`endif

  mode_e                mode_s1;
  logic [NUM_CH*SW-1:0] sym_bus;

  // Mode travels alongside its data so switches land on the exact symbol
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mode_s1 <= MODE_CTRL;
    else      mode_s1 <= mode_e'(mode);
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_lane
    logic [DW-1:0]       d_c;
    logic [3:0]          n1_d_c;
    logic [DW:0]         qm_c;
    logic [DW:0]         qm_s1;
    logic [CW-1:0]       ctrl_s1;
    logic [3:0]          n1_q_c;
    logic signed [4:0]   diff_c;
    logic signed [4:0]   cnt;
    logic signed [4:0]   cnt_nxt_c;
    logic [SW-1:0]       sym_c;
    logic [SW-1:0]       sym_s2;

    assign d_c    = data[i*DW +: DW];
    assign n1_d_c = popcount8(d_c);

    // Stage 1 transition minimisation: XOR or XNOR chain chosen by ones count
    always_comb begin
      logic xnor_sel;
      xnor_sel = (n1_d_c > 4'd4) || ((n1_d_c == 4'd4) && !d_c[0]);
      qm_c     = '0;
      qm_c[0]  = d_c[0];
      for (int k = 1; k < int'(DW); k++)
        qm_c[k] = xnor_sel ? ~(qm_c[k-1] ^ d_c[k]) : (qm_c[k-1] ^ d_c[k]);
      qm_c[DW] = ~xnor_sel;
    end

    // Stage 1 registers for this lane
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        qm_s1   <= '0;
        ctrl_s1 <= '0;
      end else begin
        qm_s1   <= qm_c;
        ctrl_s1 <= ctrl[i*CW +: CW];
      end
    end

`ifdef TMDS_TERC4_EN
    localparam logic [SW-1:0] GUARD_SYM = ((i % 2) == 0) ? 10'b1011001100 : 10'b0100110011;
    logic [AW-1:0] aux_s1;

    // TERC4 nibble follows its symbol through stage 1
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) aux_s1 <= '0;
      else      aux_s1 <= aux[i*AW +: AW];
    end
`endif

    assign n1_q_c = popcount8(qm_s1[DW-1:0]);
    // N1 - N0 = 2*N1 - 8, wraps harmlessly in 5 bits
    assign diff_c = $signed({n1_q_c, 1'b0}) - 5'sd8;

    // Stage 2 DC balancing against running disparity, or fixed-symbol modes
    always_comb begin
      sym_c     = ctrl_sym(ctrl_s1);
      cnt_nxt_c = 5'sd0;
      case (mode_s1)
        MODE_VIDEO: begin
          if ((cnt == 5'sd0) || (n1_q_c == 4'd4)) begin
            sym_c     = {~qm_s1[DW], qm_s1[DW],
                         qm_s1[DW] ? qm_s1[DW-1:0] : ~qm_s1[DW-1:0]};
            cnt_nxt_c = qm_s1[DW] ? (cnt + diff_c) : (cnt - diff_c);
          end else if ((!cnt[4] && (n1_q_c > 4'd4)) || (cnt[4] && (n1_q_c < 4'd4))) begin
            sym_c     = {1'b1, qm_s1[DW], ~qm_s1[DW-1:0]};
            cnt_nxt_c = cnt - diff_c + (qm_s1[DW] ? 5'sd2 : 5'sd0);
          end else begin
            sym_c     = {1'b0, qm_s1[DW], qm_s1[DW-1:0]};
            cnt_nxt_c = cnt + diff_c - (qm_s1[DW] ? 5'sd0 : 5'sd2);
          end
        end
`ifdef TMDS_TERC4_EN
        MODE_TERC4: sym_c = terc4_sym(aux_s1);
        MODE_GUARD: sym_c = GUARD_SYM;
`endif
        default: sym_c = ctrl_sym(ctrl_s1);
      endcase
    end

    // Stage 2 registers: symbol and running disparity
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sym_s2 <= '0;
        cnt    <= 5'sd0;
      end else begin
        sym_s2 <= sym_c;
        cnt    <= cnt_nxt_c;
      end
    end

    assign sym_bus[i*SW +: SW] = sym_s2;
  end

  if (OUT_REG != 0) begin : g_oreg
    // Optional retiming register toward the serialisers
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) tmds <= '0;
      else      tmds <= sym_bus;
    end
  end else begin : g_no_oreg
    assign tmds = sym_bus;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Directed bench for tmds_encoder_multi: 3-lane/2-cycle instance and 4-lane/3-cycle instance.
module tb_tmds_encoder_multi;

  logic        clk;
  logic        rst;
  logic [1:0]  mode3, mode4;
  logic [23:0] data3;
  logic [5:0]  ctrl3;
  logic [11:0] aux3;
  logic [29:0] tmds3;
  logic [31:0] data4;
  logic [7:0]  ctrl4;
  logic [15:0] aux4;
  logic [39:0] tmds4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tmds_encoder_multi #(.NUM_CH(3), .OUT_REG(0)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .data(data3),
    .ctrl(ctrl3), .aux(aux3), .tmds(tmds3)
  );

  tmds_encoder_multi #(.NUM_CH(4), .OUT_REG(1)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .data(data4),
    .ctrl(ctrl4), .aux(aux4), .tmds(tmds4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
`ifdef TMDS_TERC4_EN
  localparam logic [9:0] E_T8  = 10'b1011001100;
  localparam logic [9:0] E_T5  = 10'b0100011110;
  localparam logic [9:0] E_GBE = 10'b1011001100;
  localparam logic [9:0] E_GBO = 10'b0100110011;
`else
  localparam logic [9:0] E_T8  = C01;
  localparam logic [9:0] E_T5  = C10;
  localparam logic [9:0] E_GBE = C00;
  localparam logic [9:0] E_GBO = C00;
`endif

  typedef struct {
    logic [1:0] mode;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [3:0] aux;
    logic [9:0] exp_even;
    logic [9:0] exp_odd;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [9:0] act, input logic [9:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
  endtask

  // Reference DVI video encoder with running disparity held as an int
  task automatic model_video(input logic [7:0] d, input int cnt_in,
                             output logic [9:0] sym, output int cnt_out);
    int n1, ones, zeros, q8;
    bit use_xnor;
    logic [8:0] qm;
    n1 = $countones(d);
    use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int k = 1; k < 8; k++)
      qm[k] = use_xnor ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
    qm[8] = !use_xnor;
    q8 = qm[8] ? 1 : 0;
    ones = $countones(qm[7:0]);
    zeros = 8 - ones;
    cnt_out = cnt_in;
    if (cnt_in == 0 || ones == zeros) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = cnt_in + (q8 == 1 ? ones - zeros : zeros - ones);
    end else if ((cnt_in > 0 && ones > zeros) || (cnt_in < 0 && zeros > ones)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + 2 * q8 + zeros - ones;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in + ones - zeros - 2 * (1 - q8);
    end
  endtask

  task automatic drive3(input logic [1:0] m, input logic [1:0] c, input logic [7:0] d, input logic [3:0] a);
    mode3 = m;
    ctrl3 = {3{c}};
    data3 = {3{d}};
    aux3  = {3{a}};
  endtask

  initial begin
    logic [9:0] exp_sym [24][4];
    int         mcnt [4];
    logic [7:0] dl;

    rst = 1'b1;
    drive3(2'b00, 2'b00, 8'h00, 4'h0);
    mode4 = 2'b00; data4 = '0; ctrl4 = '0; aux4 = '0;

    vecs[0]  = '{2'b00, 2'b00, 8'h00, 4'h0, C00, C00};
    vecs[1]  = '{2'b00, 2'b11, 8'h00, 4'h0, C11, C11};
    vecs[2]  = '{2'b00, 2'b01, 8'h00, 4'h0, C01, C01};
    vecs[3]  = '{2'b00, 2'b10, 8'h00, 4'h0, C10, C10};
    vecs[4]  = '{2'b01, 2'b00, 8'h00, 4'h0, 10'h100, 10'h100};  // cnt -> -8
    vecs[5]  = '{2'b01, 2'b00, 8'h00, 4'h0, 10'h3FF, 10'h3FF};  // cnt -> +2
    vecs[6]  = '{2'b00, 2'b00, 8'h00, 4'h0, C00, C00};          // cnt cleared
    vecs[7]  = '{2'b01, 2'b00, 8'h00, 4'h0, 10'h100, 10'h100};  // -8
    vecs[8]  = '{2'b10, 2'b01, 8'h00, 4'h8, E_T8, E_T8};        // cleared
    vecs[9]  = '{2'b01, 2'b00, 8'hFF, 4'h0, 10'h200, 10'h200};  // -8
    vecs[10] = '{2'b11, 2'b00, 8'h00, 4'h0, E_GBE, E_GBO};      // cleared
    vecs[11] = '{2'b01, 2'b00, 8'h00, 4'h0, 10'h100, 10'h100};  // -8
    vecs[12] = '{2'b01, 2'b00, 8'h55, 4'h0, 10'h133, 10'h133};  // -8
    vecs[13] = '{2'b01, 2'b00, 8'h01, 4'h0, 10'h1FF, 10'h1FF};  // 0
    vecs[14] = '{2'b01, 2'b00, 8'h00, 4'h0, 10'h100, 10'h100};  // -8
    vecs[15] = '{2'b01, 2'b00, 8'hFF, 4'h0, 10'h0FF, 10'h0FF};  // -2
    vecs[16] = '{2'b01, 2'b00, 8'h00, 4'h0, 10'h3FF, 10'h3FF};  // +8
    vecs[17] = '{2'b01, 2'b00, 8'hFF, 4'h0, 10'h200, 10'h200};  // 0
    vecs[18] = '{2'b01, 2'b00, 8'hFF, 4'h0, 10'h200, 10'h200};  // -8
    vecs[19] = '{2'b10, 2'b10, 8'h00, 4'h5, E_T5, E_T5};

    // Power-on reset
    #2 rst = 1'b0;
    #1;
    for (int l = 0; l < 3; l++) check("por_tmds3", l, tmds3[l*10 +: 10], 10'h000);
    for (int l = 0; l < 4; l++) check("por_tmds4", l, tmds4[l*10 +: 10], 10'h000);
    step();
    step();
    rst = 1'b1;

    // Streamed vector table, two-cycle latency on the 3-lane instance
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) drive3(vecs[i].mode, vecs[i].ctrl, vecs[i].data, vecs[i].aux);
      else        drive3(2'b00, 2'b00, 8'h00, 4'h0);
      step();
      if (i >= 1)
        for (int l = 0; l < 3; l++)
          check("vec", (i - 1) * 10 + l, tmds3[l*10 +: 10],
                (l % 2 == 0) ? vecs[i-1].exp_even : vecs[i-1].exp_odd);
    end

    // Leave cnt at -8, then reset asynchronously between clock edges
    drive3(2'b01, 2'b00, 8'h00, 4'h0);
    step();
    drive3(2'b00, 2'b00, 8'h00, 4'h0);
    step();
    check("pre_rst", 0, tmds3[9:0], 10'h100);
    mode4 = 2'b01; data4 = 32'hFFFF_FFFF;
    #2 rst = 1'b0;
    #1;
    for (int l = 0; l < 3; l++) check("async_rst3", l, tmds3[l*10 +: 10], 10'h000);
    for (int l = 0; l < 4; l++) check("async_rst4", l, tmds4[l*10 +: 10], 10'h000);
    drive3(2'b01, 2'b00, 8'hFF, 4'h0);
    step();
    step();
    check("held_rst", 0, tmds3[9:0], 10'h000);
    mode4 = 2'b00; data4 = '0;

    // Release; first sampled video 0x00 must start from cnt 0
    rst = 1'b1;
    drive3(2'b01, 2'b00, 8'h00, 4'h0);
    step();
    total_cnt++;
    if (tmds3[9:0] !== 10'h100) pass_cnt++;
    else $display("FAIL early_symbol: got %b one edge after sampling, required a later symbol", tmds3[9:0]);
    drive3(2'b00, 2'b00, 8'h00, 4'h0);
    step();
    for (int l = 0; l < 3; l++) check("post_rst", l, tmds3[l*10 +: 10], 10'h100);

    // Throughput on the 4-lane instance: new data every cycle, three-cycle latency
    for (int l = 0; l < 4; l++) mcnt[l] = 0;
    for (int c = 0; c < 26; c++) begin
      if (c < 24) begin
        mode4 = 2'b01;
        for (int l = 0; l < 4; l++) begin
          dl = 8'(c * 4 + l);
          data4[l*8 +: 8] = dl;
          model_video(dl, mcnt[l], exp_sym[c][l], mcnt[l]);
        end
      end else begin
        mode4 = 2'b00;
        data4 = '0;
      end
      step();
      if (c >= 2)
        for (int l = 0; l < 4; l++)
          check("thru", (c - 2) * 10 + l, tmds4[l*10 +: 10], exp_sym[c-2][l]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
